// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount in quarters, dimes and nickels,
// largest first, confirming each coin on the exit sensor and flagging jams.
module change_dispenser #(
  parameter int AMT_W          = 8,
  parameter int Q_VAL          = 25,
  parameter int D_VAL          = 10,
  parameter int N_VAL          = 5,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             hopper_q_empty,
  input  logic             hopper_d_empty,
  input  logic             hopper_n_empty,
  input  logic             coin_sensed,
  output logic             eject_q,
  output logic             eject_d,
  output logic             eject_n,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic             jam
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > PULSE_CYCLES) ? TIMEOUT_CYCLES : PULSE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_SENSE, DONE} state_t;

  state_t           state, state_nxt;
  logic [AMT_W-1:0] remaining, remaining_nxt;
  logic [2:0]       fail_mask, fail_mask_nxt;  // {Q, D, N}
  logic [2:0]       coin_sel, coin_sel_nxt;    // one-hot {Q, D, N}
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sensed, sensed_nxt;
  logic             jam_flag, jam_flag_nxt;
  logic             q_ok, d_ok, n_ok;

  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] sel);
    if (sel[2])      return AMT_W'(Q_VAL);
    else if (sel[1]) return AMT_W'(D_VAL);
    else             return AMT_W'(N_VAL);
  endfunction

  assign q_ok = (remaining >= AMT_W'(Q_VAL)) && !hopper_q_empty && !fail_mask[2];
  assign d_ok = (remaining >= AMT_W'(D_VAL)) && !hopper_d_empty && !fail_mask[1];
  assign n_ok = (remaining >= AMT_W'(N_VAL)) && !hopper_n_empty && !fail_mask[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      fail_mask <= '0;
      coin_sel  <= '0;
      cnt       <= '0;
      sensed    <= 1'b0;
      jam_flag  <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      fail_mask <= fail_mask_nxt;
      coin_sel  <= coin_sel_nxt;
      cnt       <= cnt_nxt;
      sensed    <= sensed_nxt;
      jam_flag  <= jam_flag_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    fail_mask_nxt = fail_mask;
    coin_sel_nxt  = coin_sel;
    cnt_nxt       = cnt;
    sensed_nxt    = sensed;
    jam_flag_nxt  = jam_flag;
    case (state)
      IDLE: begin
        if (req_valid) begin
          remaining_nxt = req_amount;
          fail_mask_nxt = '0;
          jam_flag_nxt  = 1'b0;
          state_nxt     = SELECT;
        end
      end
      SELECT: begin
        sensed_nxt = 1'b0;
        cnt_nxt    = CNT_W'(PULSE_CYCLES - 1);
        if (q_ok)      begin coin_sel_nxt = 3'b100; state_nxt = EJECT; end
        else if (d_ok) begin coin_sel_nxt = 3'b010; state_nxt = EJECT; end
        else if (n_ok) begin coin_sel_nxt = 3'b001; state_nxt = EJECT; end
        else                                        state_nxt = DONE;
      end
      EJECT: begin
        // A coin can reach the sensor before the pulse ends; remember it.
        if (coin_sensed) sensed_nxt = 1'b1;
        if (cnt == '0) begin
          cnt_nxt   = CNT_W'(TIMEOUT_CYCLES - 1);
          state_nxt = WAIT_SENSE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      WAIT_SENSE: begin
        if (sensed || coin_sensed) begin
          remaining_nxt = remaining - coin_value(coin_sel);
          state_nxt     = SELECT;
        end else if (cnt == '0) begin
          fail_mask_nxt = fail_mask | coin_sel;
          jam_flag_nxt  = 1'b1;
          state_nxt     = SELECT;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset silences the solenoids at once.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign eject_q   = (state == EJECT) && coin_sel[2];
  assign eject_d   = (state == EJECT) && coin_sel[1];
  assign eject_n   = (state == EJECT) && coin_sel[0];
  assign done      = (state == DONE);
  assign shortfall = (state == DONE) ? remaining : '0;
  assign jam       = (state == DONE) && jam_flag;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy change-making model.
module tb_change_dispenser;
  localparam int AMT_W = 8;
  localparam int PULSE = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount = '0;
  logic             hopper_q_empty = 1'b0;
  logic             hopper_d_empty = 1'b0;
  logic             hopper_n_empty = 1'b0;
  logic             coin_sensed = 1'b0;
  logic             eject_q, eject_d, eject_n, busy, done, jam;
  logic [AMT_W-1:0] shortfall;

  int n_checks = 0;
  int n_errors = 0;
  bit sense_plan [64];
  bit early_plan [64];
  int exp_coins [$];

  always #5 clk = ~clk;

  change_dispenser #(.AMT_W(AMT_W), .PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_amount(req_amount), .hopper_q_empty(hopper_q_empty),
    .hopper_d_empty(hopper_d_empty), .hopper_n_empty(hopper_n_empty),
    .coin_sensed(coin_sensed), .eject_q(eject_q), .eject_d(eject_d),
    .eject_n(eject_n), .busy(busy), .done(done), .shortfall(shortfall), .jam(jam)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Greedy payout: each coin attempt either lands (amount drops) or jams
  // (that denomination is abandoned for the rest of the transaction).
  task automatic model(input int amt, input bit qe, input bit de, input bit ne,
                       output int sf, output bit jm);
    int  vals [3];
    bit  avail [3];
    int  rem, k;
    bit  found;
    vals = '{25, 10, 5};
    avail = '{!qe, !de, !ne};
    rem = amt; k = 0; jm = 0;
    exp_coins.delete();
    forever begin
      found = 0;
      for (int c = 0; c < 3; c++) begin
        if (!found && avail[c] && vals[c] <= rem) begin
          found = 1;
          exp_coins.push_back(4 >> c);
          if (sense_plan[k]) rem -= vals[c];
          else begin avail[c] = 0; jm = 1; end
          k++;
        end
      end
      if (!found) break;
    end
    sf = rem;
  endtask

  task automatic run_txn(input int amt, input bit qe, input bit de, input bit ne);
    int exp_sf, cyc, k, plen, dly, first_ej;
    bit exp_jam, got_done, pend;
    logic [2:0] ej, prev_ej;
    model(amt, qe, de, ne, exp_sf, exp_jam);
    hopper_q_empty = qe; hopper_d_empty = de; hopper_n_empty = ne;
    cyc = 0;
    while (!req_ready && cyc < 100) begin @(negedge clk); cyc++; end
    chk("ready_before_req", int'(req_ready), 1);
    req_amount = AMT_W'(amt);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; k = 0; plen = 0; dly = 0; pend = 0; first_ej = -1; got_done = 0;
    prev_ej = 3'b000;
    while (cyc < 6000) begin
      coin_sensed = 1'b0;
      ej = {eject_q, eject_d, eject_n};
      if (ej != 3'b000) begin
        if (prev_ej == 3'b000) begin
          if (first_ej < 0) first_ej = cyc;
          chk("eject_onehot", $countones(ej), 1);
          if (k < exp_coins.size()) chk("coin", int'(ej), exp_coins[k]);
          else chk("extra_coin", int'(ej), 0);
          plen = 1;
        end else plen++;
        if (plen == 2 && k < 64 && sense_plan[k] && early_plan[k]) coin_sensed = 1'b1;
      end else if (prev_ej != 3'b000) begin
        chk("pulse_len", plen, PULSE);
        if (k < 64 && sense_plan[k] && !early_plan[k]) begin
          pend = 1; dly = $urandom_range(0, 5);
        end
        k++;
      end
      if (pend) begin
        if (dly == 0) begin coin_sensed = 1'b1; pend = 0; end
        else dly--;
      end
      if (done) begin
        got_done = 1;
        chk("shortfall", int'(shortfall), exp_sf);
        chk("jam", int'(jam), int'(exp_jam));
        chk("coin_count", k, exp_coins.size());
        if (exp_coins.size() > 0) chk("first_eject_cycle", first_ej, 2);
        else chk("done_cycle", cyc, 2);
        break;
      end
      prev_ej = ej;
      @(negedge clk);
      cyc++;
    end
    coin_sensed = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("ready_after_done", int'(req_ready), 1);
    chk("shortfall_idle", int'(shortfall), 0);
  endtask

  task automatic plan_all_sensed();
    for (int i = 0; i < 64; i++) begin sense_plan[i] = 1; early_plan[i] = 0; end
  endtask

  initial begin
    int cyc;
    plan_all_sensed();
    #12;
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_eject", int'({eject_q, eject_d, eject_n}), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_shortfall", int'(shortfall), 0);
    chk("rst_jam", int'(jam), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_txn(40, 0, 0, 0);
    run_txn(30, 1, 0, 0);
    run_txn(7, 0, 0, 0);
    sense_plan[0] = 0;
    run_txn(25, 0, 0, 0);
    plan_all_sensed();
    run_txn(0, 0, 0, 0);
    run_txn(15, 1, 1, 1);
    for (int i = 0; i < 64; i++) early_plan[i] = (i % 2 == 1);
    run_txn(65, 0, 0, 0);
    plan_all_sensed();

    // Reset in the middle of a quarter pulse.
    hopper_q_empty = 0; hopper_d_empty = 0; hopper_n_empty = 0;
    req_amount = 8'd25; req_valid = 1'b1;
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    cyc = 0;
    while (!eject_q && cyc < 20) begin @(negedge clk); cyc++; end
    chk("eject_q_seen", int'(eject_q), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_eject_q", int'(eject_q), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(req_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_txn(10, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 64; i++) begin
        sense_plan[i] = ($urandom_range(0, 15) != 0);
        early_plan[i] = ($urandom_range(0, 2) == 0);
      end
      run_txn($urandom_range(0, 120), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays change back to the customer once the juice seller finishes a sale.
- Accepts a change amount in cents over a valid/ready handshake.
- Drives quarter, dime and nickel hopper eject solenoids, largest coin first, and confirms each coin on the exit sensor.
- Reports completion with any unpaid shortfall and a jam flag. Sits between the seller FSM and the coin hoppers.

Parameters:
- AMT_W, 8, width of amount and shortfall in cents.
- Q_VAL, 25, quarter value.
- D_VAL, 10, dime value.
- N_VAL, 5, nickel value.
- PULSE_CYCLES, 4, eject solenoid pulse length in clk cycles (>=1).
- TIMEOUT_CYCLES, 1000, cycles to wait for the exit sensor after the pulse ends (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  change request present.
- req_ready  out  1  block can accept a request.
- req_amount  in  AMT_W  change to pay in cents; sampled on acceptance.
- hopper_q_empty  in  1  quarter hopper empty.
- hopper_d_empty  in  1  dime hopper empty.
- hopper_n_empty  in  1  nickel hopper empty.
- coin_sensed  in  1  exit sensor; high for >=1 cycle per coin (already synchronous).
- eject_q  out  1  quarter solenoid.
- eject_d  out  1  dime solenoid.
- eject_n  out  1  nickel solenoid.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- shortfall  out  AMT_W  unpaid cents; valid while done=1, otherwise 0.
- jam  out  1  valid with done; 1 if any coin timed out this transaction, otherwise 0.

Behaviour:
- Reset: all outputs 0 except req_ready=1. State=IDLE, remaining=0, masks cleared. Reset takes effect immediately, mid-operation included; any eject line drops at once.
- States: IDLE, SELECT, EJECT, WAIT_SENSE, DONE.
- req_ready=1 only in IDLE. busy=1 in every other state.
- IDLE: when req_valid && req_ready at an edge, latch remaining=req_amount, clear the per-hopper fail mask and the jam flag, then go to SELECT.
- SELECT (single cycle): pick the first eligible coin in the order Q, D, N. A coin is eligible when value <= remaining, its hopper is not empty (sampled this cycle), and it is not in the fail mask.
  - If a coin is eligible: go to EJECT and load the pulse counter.
  - Otherwise: go to DONE with shortfall=remaining. This covers remaining=0, non-multiples of 5, and all hoppers exhausted.
- EJECT: assert exactly one eject line for PULSE_CYCLES consecutive cycles, then go to WAIT_SENSE and load the timeout counter. A coin_sensed seen during EJECT is latched.
- WAIT_SENSE:
  - If coin_sensed was latched, or coin_sensed=1 this cycle: remaining -= coin value, then go to SELECT.
  - If TIMEOUT_CYCLES elapse without a sense: set that coin in the fail mask, set jam, leave remaining unchanged, then go to SELECT.
  - Only the first sense per coin counts. coin_sensed in IDLE, SELECT or DONE is ignored.
- DONE: done=1, shortfall driven, jam driven, for exactly one cycle, then IDLE.
- Latency:
  - Request accepted at edge T: SELECT in cycle T+1.
  - First eject in cycles T+2 .. T+1+PULSE_CYCLES.
  - Amount 0: done in cycle T+2, req_ready=1 in cycle T+3.
- remaining never underflows, because a coin is only chosen when its value <= remaining.
- req_valid while busy has no effect; the request stays pending for the requester.
- A hopper going empty mid-transaction is honoured at the next SELECT.

Test Plan:
- Hoppers full, req_amount=40 -> eject_q, then eject_d, then eject_n, each pulse 4 cycles with a sense after each; done with shortfall=0, jam=0.
- hopper_q_empty=1, req_amount=30 -> three eject_d pulses, no eject_q; done shortfall=0.
- req_amount=7 -> one eject_n; done shortfall=2.
- req_amount=25, quarter never sensed -> eject_q, then timeout after 1000 cycles; then eject_d, eject_d, eject_n; done shortfall=0, jam=1.
- req_amount=0 accepted at T -> done=1 in cycle T+2 with shortfall=0, no eject lines; req_ready=1 in T+3. Also req_amount=15 with all hoppers empty -> done shortfall=15.
- rst_n low during an eject_q pulse -> eject_q and busy drop the same cycle; after release, req_ready=1, and a new request of 10 dispenses one dime normally.
